// File: rtl/seu_parity_checker_pkg.sv
// rtl/seu_parity_checker_pkg.sv - shared state type and parity helper for the SEU parity checker
package seu_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        HOLDOFF = 1'b1
    } seu_state_t;

    // Widest word the parity helper accepts; narrower words are zero-extended,
    // which leaves the XOR reduction unchanged.
    localparam int PARITY_MAX_W = 256;

    // Even parity: the bit that makes the total number of ones even (XOR of all bits).
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/seu_parity_checker_sat_counter.sv
// rtl/seu_parity_checker_sat_counter.sv - saturating up-counter with same-cycle clear-then-increment
module seu_sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_VAL = '1;

    logic [W-1:0] r_cnt;

    // clr wipes the count first, then a coincident inc lands on the cleared value
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= inc ? W'(1) : '0;
        end else if (inc && (r_cnt != MAX_VAL)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign count = r_cnt;

endmodule

// File: rtl/seu_parity_checker.sv
// rtl/seu_parity_checker.sv - parity-checking valid/ready stage with error count, scrub holdoff, optional SEU_CHECK_LOG_EN capture log
module seu_parity_checker
    import seu_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int CNT_WIDTH      = 8,
    parameter int HOLDOFF_CYCLES = 4,
    parameter int DROP_ON_ERR    = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_parity,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_err,
    output logic                 err_pulse,
    output logic                 err_sticky,
    output logic [CNT_WIDTH-1:0] err_count,
`ifdef SEU_CHECK_LOG_EN
    output logic [WIDTH-1:0]     log_data,
    output logic [31:0]          log_cycle,
`endif
    input  logic                 clear_count
);

    localparam int               HCW       = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam bit               HOLD_EN   = (HOLDOFF_CYCLES > 0);
    localparam bit               DROP      = (DROP_ON_ERR != 0);
    localparam logic [HCW-1:0]   HOLD_LOAD = HOLD_EN ? HCW'(HOLDOFF_CYCLES - 1) : '0;

    seu_state_t       r_state;
    seu_state_t       w_state_next;
    logic [HCW-1:0]   r_hold_cnt;
    logic [HCW-1:0]   w_hold_next;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_err;
    logic             r_err_pulse;
    logic             r_err_sticky;
    logic             w_accept;
    logic             w_mismatch;
    logic             w_err_acc;
    logic             w_load;

    // Ready is combinational from out_ready so a draining register can refill in the same cycle
    assign in_ready   = (r_state == RUN) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_mismatch = even_parity(PARITY_MAX_W'(in_data)) ^ in_parity;
    assign w_err_acc  = w_accept && w_mismatch;
    assign w_load     = w_accept && (!w_mismatch || !DROP);

    // Scrub-window state and down-counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= RUN;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_hold_cnt <= w_hold_next;
        end
    end

    // Enter HOLDOFF on an error; leave the cycle after the counter reads zero
    always_comb begin
        w_state_next = r_state;
        w_hold_next  = r_hold_cnt;
        case (r_state)
            RUN: begin
                if (w_err_acc && HOLD_EN) begin
                    w_state_next = HOLDOFF;
                    w_hold_next  = HOLD_LOAD;
                end
            end
            HOLDOFF: begin
                if (r_hold_cnt == '0) begin
                    w_state_next = RUN;
                end else begin
                    w_hold_next = r_hold_cnt - HCW'(1);
                end
            end
            default: begin
                w_state_next = RUN;
                w_hold_next  = '0;
            end
        endcase
    end

    // One-entry output register: a load wins over a drain, so the new word replaces the old
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data;
            r_out_err   <= w_mismatch;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
        end
    end

    // Error pulse follows each erroneous accept; sticky flag holds until clear_count
    always_ff @(posedge clock) begin
        if (reset) begin
            r_err_pulse  <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            r_err_pulse <= w_err_acc;
            if (w_err_acc) begin
                r_err_sticky <= 1'b1;
            end else if (clear_count) begin
                r_err_sticky <= 1'b0;
            end
        end
    end

    seu_sat_counter #(
        .W (CNT_WIDTH)
    ) u_err_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (clear_count),
        .inc   (w_err_acc),
        .count (err_count)
    );

`ifdef SEU_CHECK_LOG_EN
    logic [31:0]      r_cycle;
    logic [WIDTH-1:0] r_log_data;
    logic [31:0]      r_log_cycle;

    // Free-running cycle stamp and capture of the most recent corrupted word
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cycle     <= '0;
            r_log_data  <= '0;
            r_log_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_err_acc) begin
                r_log_data  <= in_data;
                r_log_cycle <= r_cycle;
            end
        end
    end

    assign log_data  = r_log_data;
    assign log_cycle = r_log_cycle;
`endif

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_err    = r_out_err;
    assign err_pulse  = r_err_pulse;
    assign err_sticky = r_err_sticky;

endmodule
